// File: rtl/immgen_pkg.sv
// rtl/immgen_pkg.sv - immediate format codes, opcode constants and opcode-to-format decode
package immgen_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } imm_fmt_e;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // Every listed opcode ends in 2'b11, so a compressed-style encoding falls out as FMT_NONE.
   function automatic imm_fmt_e decode_fmt(input logic [6:0] opcode);
      imm_fmt_e f;
      case (opcode)
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: f = FMT_I;
         OPC_STORE:                                  f = FMT_S;
         OPC_BRANCH:                                 f = FMT_B;
         OPC_LUI, OPC_AUIPC:                         f = FMT_U;
         OPC_JAL:                                    f = FMT_J;
         default:                                    f = FMT_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/immgen_extract.sv
// rtl/immgen_extract.sv - combinational immediate extraction and sign extension to XLEN
module immgen_extract
   import immgen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     ir,
   input  imm_fmt_e        fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (fmt)
         FMT_I:   imm32 = {{20{ir[31]}}, ir[31:20]};
         FMT_S:   imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         FMT_B:   imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         FMT_U:   imm32 = {ir[31:12], 12'b0};
         FMT_J:   imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   if (XLEN == 32) begin : g_x32
      assign imm = imm32;
   end else begin : g_wide
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
   end

endmodule

// File: rtl/immed_gen_pipe.sv
// rtl/immed_gen_pipe.sv - two-stage immediate generator with valid/ready flow control
// Optional IMMGEN_ILLEGAL_EN adds a registered illegal-opcode output.
module immed_gen_pipe
   import immgen_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ILEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ILEN-1:0] ir,
   input  logic [XLEN-1:0] pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic [XLEN-1:0] target
`ifdef IMMGEN_ILLEGAL_EN
   ,
   output logic            illegal
`endif
);

   if (ILEN != 32) begin : g_bad_ilen
      $error("immed_gen_pipe: ILEN must be 32");
   end
   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("immed_gen_pipe: XLEN must be 32 or 64");
   end

   logic            s1_valid;
   logic [31:7]     s1_ir;
   logic [XLEN-1:0] s1_pc;
   imm_fmt_e        s1_fmt;
   logic            s2_adv;
   logic [XLEN-1:0] x_imm;

   // The only combinational input-to-output path is out_ready -> in_ready.
   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;

   immgen_extract #(.XLEN(XLEN)) u_extract (
      .ir  (s1_ir),
      .fmt (s1_fmt),
      .imm (x_imm)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_ir     <= '0;
         s1_pc     <= '0;
         s1_fmt    <= FMT_NONE;
         out_valid <= 1'b0;
         imm       <= '0;
         fmt       <= '0;
         target    <= '0;
`ifdef IMMGEN_ILLEGAL_EN
         illegal   <= 1'b0;
`endif
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_ir  <= ir[31:7];
               s1_pc  <= pc;
               s1_fmt <= decode_fmt(ir[6:0]);
            end
         end
         // Output registers only load with a real item, so an empty pipe keeps its last values.
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               imm    <= x_imm;
               fmt    <= s1_fmt;
               target <= s1_pc + x_imm;
`ifdef IMMGEN_ILLEGAL_EN
               illegal <= (s1_fmt == FMT_NONE);
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_immed_gen_pipe.sv
// tb/tb_immed_gen_pipe.sv - table-driven scoreboard bench for XLEN=32 and XLEN=64 instances
module tb_immed_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] ir;
   logic [63:0] pc;

   logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
   logic [31:0] imm_a, target_a;
   logic [63:0] imm_b, target_b;
   logic [2:0]  fmt_a, fmt_b;
`ifdef IMMGEN_ILLEGAL_EN
   logic        illegal_a, illegal_b;
`endif

   always #5 clk = ~clk;

   immed_gen_pipe #(.XLEN(32), .ILEN(32)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a),
      .ir        (ir),
      .pc        (pc[31:0]),
      .out_valid (out_valid_a),
      .out_ready (out_ready),
      .imm       (imm_a),
      .fmt       (fmt_a),
      .target    (target_a)
`ifdef IMMGEN_ILLEGAL_EN
      ,
      .illegal   (illegal_a)
`endif
   );

   immed_gen_pipe #(.XLEN(64), .ILEN(32)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_b),
      .ir        (ir),
      .pc        (pc),
      .out_valid (out_valid_b),
      .out_ready (out_ready),
      .imm       (imm_b),
      .fmt       (fmt_b),
      .target    (target_b)
`ifdef IMMGEN_ILLEGAL_EN
      ,
      .illegal   (illegal_b)
`endif
   );

   typedef struct {
      logic [31:0] ir;
      logic [63:0] pc;
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic [63:0] target;
      logic        illegal;
   } vec_t;

   typedef struct {
      vec_t v;
      int   acc;
      bit   lat;
   } sb_t;

   vec_t tv [16];
   sb_t  sb [$];
   vec_t cur;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   lat_mode = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: push on input transfer, pop and compare on output transfer.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (in_valid && in_ready_a)
            sb.push_back('{v: cur, acc: cyc, lat: lat_mode});
         if (out_valid_a && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got imm 0x%0h expected no output", imm_a);
            end else begin
               sb_t e;
               e = sb.pop_front();
               chk("out_valid64", 64'(out_valid_b), 64'd1);
               chk("imm32",    64'(imm_a),    64'(e.v.imm[31:0]));
               chk("fmt32",    64'(fmt_a),    64'(e.v.fmt));
               chk("target32", 64'(target_a), 64'(e.v.target[31:0]));
               chk("imm64",    imm_b,         e.v.imm);
               chk("fmt64",    64'(fmt_b),    64'(e.v.fmt));
               chk("target64", target_b,      e.v.target);
`ifdef IMMGEN_ILLEGAL_EN
               chk("illegal32", 64'(illegal_a), 64'(e.v.illegal));
               chk("illegal64", 64'(illegal_b), 64'(e.v.illegal));
`endif
               if (e.lat)
                  chk("latency", 64'(cyc - e.acc), 64'd2);
            end
         end
      end
   end

   task automatic send(input int idx);
      int  t;
      bit  acc;
      t = 0;
      acc = 1'b0;
      cur = tv[idx];
      ir = cur.ir;
      pc = cur.pc;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready_a;
         @(posedge clk);
         #1;
         t++;
      end while (!acc && t < 50);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready 0 expected 1 for vector %0d", idx);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] s_imm_b, s_tgt_b;
      logic [31:0] s_imm_a, s_tgt_a;
      logic [2:0]  s_fmt;

      tv[0]  = '{32'hFFF00093, 64'h100,  64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'hFF,                  1'b0};
      tv[1]  = '{32'hFE112E23, 64'h100,  64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 64'hFC,                  1'b0};
      tv[2]  = '{32'hFE000CE3, 64'h100,  64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 64'hF8,                  1'b0};
      tv[3]  = '{32'h123450B7, 64'h100,  64'h0000_0000_1234_5000, 3'd4, 64'h1234_5100,           1'b0};
      tv[4]  = '{32'h800000B7, 64'h100,  64'hFFFF_FFFF_8000_0000, 3'd4, 64'hFFFF_FFFF_8000_0100, 1'b0};
      tv[5]  = '{32'h0010006F, 64'h1000, 64'h800,                 3'd5, 64'h1800,                1'b0};
      tv[6]  = '{32'h0000007F, 64'h200,  64'h0,                   3'd0, 64'h200,                 1'b1};
      tv[7]  = '{32'h00000013, 64'h300,  64'h0,                   3'd1, 64'h300,                 1'b0};
      tv[8]  = '{32'h010100E7, 64'h400,  64'h10,                  3'd1, 64'h410,                 1'b0};
      tv[9]  = '{32'hFFFFF097, 64'h2000, 64'hFFFF_FFFF_FFFF_F000, 3'd4, 64'h1000,                1'b0};
      tv[10] = '{32'h00000010, 64'h500,  64'h0,                   3'd0, 64'h500,                 1'b1};
      tv[11] = '{32'h02000013, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20,   3'd1, 64'h10,                  1'b0};
      tv[12] = '{32'h00402083, 64'h0,    64'h4,                   3'd1, 64'h4,                   1'b0};
      tv[13] = '{32'h00000073, 64'h600,  64'h0,                   3'd1, 64'h600,                 1'b0};
      tv[14] = '{32'h00001463, 64'h700,  64'h8,                   3'd3, 64'h708,                 1'b0};
      tv[15] = '{32'hFFDFF06F, 64'h800,  64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 64'h7FC,                 1'b0};

      // Reset held three edges with in_valid asserted.
      cur = tv[0];
      rst_n = 1'b0;
      in_valid = 1'b1;
      ir = tv[0].ir;
      pc = tv[0].pc;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_out_valid32", 64'(out_valid_a), 64'd0);
         chk("rst_out_valid64", 64'(out_valid_b), 64'd0);
         chk("rst_imm32",       64'(imm_a),       64'd0);
         chk("rst_imm64",       imm_b,            64'd0);
         chk("rst_fmt32",       64'(fmt_a),       64'd0);
         chk("rst_fmt64",       64'(fmt_b),       64'd0);
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_in_ready32", 64'(in_ready_a), 64'd1);
      chk("rst_in_ready64", 64'(in_ready_b), 64'd1);
      @(posedge clk);
      #1;

      // Full table, back-to-back, no backpressure: latency must be exactly 2.
      lat_mode = 1'b1;
      for (int i = 0; i < 16; i++) send(i);
      lat_mode = 1'b0;
      drain();

      // Backpressure: five items streamed, out_ready low for four cycles mid-stream.
      fork
         begin
            for (int i = 0; i < 5; i++) send(i);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               if (k == 0) begin
                  s_imm_a = imm_a;
                  s_tgt_a = target_a;
                  s_imm_b = imm_b;
                  s_tgt_b = target_b;
                  s_fmt   = fmt_a;
               end
               chk("stall_out_valid", 64'(out_valid_a), 64'd1);
               chk("stall_in_ready",  64'(in_ready_a),  64'd0);
               chk("stall_imm32",     64'(imm_a),       64'(s_imm_a));
               chk("stall_target32",  64'(target_a),    64'(s_tgt_a));
               chk("stall_imm64",     imm_b,            s_imm_b);
               chk("stall_target64",  target_b,         s_tgt_b);
               chk("stall_fmt",       64'(fmt_a),       64'(s_fmt));
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Mid-operation reset with two items in flight: they must never appear.
      out_ready = 1'b0;
      send(5);
      send(2);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid32", 64'(out_valid_a), 64'd0);
      chk("midrst_out_valid64", 64'(out_valid_b), 64'd0);
      chk("midrst_in_ready",    64'(in_ready_a),  64'd1);
      chk("midrst_imm64",       imm_b,            64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(8);
      drain();
      repeat (3) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
